cim_acc_buffer: RTL and testbench
=================================

Name: cim_acc_buffer

Overview:
- Partial-sum accumulation store directly downstream of the CIM adder stage.
- Holds one 512-bit packed 6x6 tile of 12-bit sums per address.
- Supplies the stored tile (memory_data/addr/valid) back to the adder for read-modify-write.
- Captures the adder's result_o at result_addr_o; provides bulk clear and a ready/valid drain of final sums to the writeback path.

Parameters:
- DEPTH, 256, number of tile entries; must equal 2**ADDR_W.
- ADDR_W, 8, address width; matches PE_addr/memory_addr/result_addr.
- DATA_W, 512, entry width (36 x 12-bit tile packed in bits [431:0], bits [511:432] zero).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_req_valid_i  in  1  request to fetch entry rd_req_addr_i for accumulation.
- rd_req_addr_i  in  ADDR_W  entry to fetch.
- memory_data_o  out  DATA_W  fetched entry, to adder memory_data_i.
- memory_addr_o  out  ADDR_W  address of memory_data_o.
- memory_valid_o  out  1  memory_data_o/addr valid this cycle.
- wr_valid_i  in  1  write strobe, from adder result_valid_o.
- wr_addr_i  in  ADDR_W  write address, from adder result_addr_o.
- wr_data_i  in  DATA_W  write data, from adder result_o.
- clear_i  in  1  pulse: zero all entries.
- drain_i  in  1  pulse: stream out all entries, address 0 upward.
- drain_data_o  out  DATA_W  drained entry.
- drain_addr_o  out  ADDR_W  address of drained entry.
- drain_valid_o  out  1  drain beat valid.
- drain_ready_i  in  1  downstream accepts drain beat.
- busy_o  out  1  high in CLEAR or DRAIN.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs go to 0: memory_*, drain_*, busy_o.
  - Clear/drain pointers go to 0.
  - Storage array is NOT reset.
  - Reset mid-CLEAR/DRAIN aborts immediately. Entries already zeroed stay zero; the others keep their contents.
- Storage: DEPTH x DATA_W register array. Write takes effect at the clock edge.
- IDLE read path, 1-cycle latency:
  - rd_req_valid_i at cycle t sets memory_valid_o=1 at t+1, with memory_addr_o = rd_req_addr_i.
  - memory_data_o = mem[addr] as of the end of cycle t.
  - Otherwise memory_valid_o=0 at t+1; data/addr hold their last values.
- Same-cycle hazard: if wr_valid_i && rd_req_valid_i && wr_addr_i==rd_req_addr_i at cycle t, memory_data_o at t+1 = wr_data_i (forwarded). A read never returns the value being overwritten.
- IDLE write: wr_valid_i writes wr_data_i to mem[wr_addr_i]. Writes and reads to different addresses proceed in the same cycle.
- FSM states: IDLE, CLEAR, DRAIN.
- IDLE transitions:
  - clear_i goes to CLEAR with ptr=0.
  - Else drain_i goes to DRAIN with ptr=0.
  - clear_i wins when both are asserted together.
- CLEAR:
  - Each cycle writes mem[ptr]=0 and increments ptr.
  - After ptr==DEPTH-1 is written, return to IDLE. Total DEPTH cycles.
- DRAIN:
  - On entry, register mem[0] onto drain_data_o with drain_addr_o=0 and drain_valid_o=1. The first beat appears the cycle after the IDLE->DRAIN edge.
  - While drain_valid_o && !drain_ready_i, data/addr/valid hold stable.
  - On acceptance (valid && ready) with addr<DEPTH-1, present mem[addr+1] next cycle. Beats are back-to-back at full throughput.
  - On acceptance of addr==DEPTH-1, drain_valid_o=0 and state returns to IDLE.
  - Entries are not modified by drain.
- Busy behaviour:
  - busy_o=1 exactly while state is CLEAR or DRAIN.
  - While busy, rd_req_valid_i, wr_valid_i, clear_i and drain_i are ignored (dropped, not queued), and memory_valid_o=0. Upstream must stall on busy_o.
- Address wrap: ptr never wraps; termination occurs at DEPTH-1.
- No arithmetic in this block; data passes through bit-exact.

Test Plan:
- Reset, then clear_i pulse -> busy_o high for exactly 256 cycles. Afterwards, reads of addr 0, 128 and 255 return 512'h0 with memory_valid_o 1 cycle after each request.
- Write addr 5 = tile with all elements 12'h001. Next cycle read addr 5 -> memory_data_o = that tile, memory_addr_o=5, one cycle latency.
- Same cycle: write addr 9 = X with rd_req addr 9 (old value Y) -> memory_data_o = X next cycle. Repeat with write addr 10 -> returns Y.
- Full RMW loop with the adder model: four accumulations of PE tile value 3 into addr 7, after clear -> stored elements = 12 (12'h00C). Then an accumulation of -12 -> 0.
- Drain with drain_ready_i toggling 1,0,0,1 repeatedly -> 256 beats, addresses 0..255 in order, no duplicates or drops. Data holds while ready is low; busy_o drops the cycle after beat 255 is accepted.
- reset asserted at clear cycle 100 -> IDLE next cycle, busy_o=0. Entries 0..99 read 0; entry 200 keeps its pre-clear value. Same-cycle clear_i+drain_i -> CLEAR taken, no drain beats.

Source files
------------

// File: rtl/cim_acc_buffer.sv
// cim_acc_buffer
// Partial-sum accumulation store that sits right after the CIM adder stage.
// Each entry holds one packed 6x6 tile of 12-bit sums. The block serves
// read-modify-write traffic from the adder while idle. It also provides a
// bulk clear of every entry and a ready/valid drain of all entries, in
// address order, to the writeback path.
module cim_acc_buffer #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              reset,

    // Fetch request from the accumulation pipeline
    input  logic              rd_req_valid_i,
    input  logic [ADDR_W-1:0] rd_req_addr_i,

    // Fetched entry returned to the adder
    output logic [DATA_W-1:0] memory_data_o,
    output logic [ADDR_W-1:0] memory_addr_o,
    output logic              memory_valid_o,

    // Adder result write-back
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,

    // Bulk operations
    input  logic              clear_i,
    input  logic              drain_i,

    // Drain stream to writeback
    output logic [DATA_W-1:0] drain_data_o,
    output logic [ADDR_W-1:0] drain_addr_o,
    output logic              drain_valid_o,
    input  logic              drain_ready_i,

    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    // Storage array. It is deliberately left out of reset: a reset that
    // lands mid-clear must leave the not-yet-cleared entries untouched.
    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // Single write port, shared by adder write-back and the clear sweep
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Registered fetch path
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_valid_q, mem_valid_d;

    // Registered drain beat
    logic [DATA_W-1:0] drain_data_q, drain_data_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic              drain_valid_q, drain_valid_d;

    logic [ADDR_W-1:0] drain_addr_next;
    logic              rd_hits_wr;
    logic              drain_first_hits_wr;

    assign drain_addr_next     = drain_addr_q + ADDR_ONE;
    // A write landing on the address being fetched this cycle is forwarded,
    // so a fetch never returns the value that is being overwritten.
    assign rd_hits_wr          = wr_valid_i && (wr_addr_i == rd_req_addr_i);
    assign drain_first_hits_wr = wr_valid_i && (wr_addr_i == '0);

    // Next-state, storage write control and output-register next values
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        mem_we        = 1'b0;
        mem_waddr     = wr_addr_i;
        mem_wdata     = wr_data_i;
        mem_valid_d   = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_data_d    = mem_data_q;
        drain_valid_d = drain_valid_q;
        drain_addr_d  = drain_addr_q;
        drain_data_d  = drain_data_q;

        case (state_q)
            ST_IDLE: begin
                mem_we = wr_valid_i;
                if (rd_req_valid_i) begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = rd_req_addr_i;
                    mem_data_d  = rd_hits_wr ? wr_data_i : mem[rd_req_addr_i];
                end
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end else if (drain_i) begin
                    // First beat is presented the cycle after entry
                    state_d       = ST_DRAIN;
                    ptr_d         = '0;
                    drain_valid_d = 1'b1;
                    drain_addr_d  = '0;
                    drain_data_d  = drain_first_hits_wr ? wr_data_i : mem[0];
                end
            end

            ST_CLEAR: begin
                // One entry zeroed per cycle; external traffic is dropped
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_ONE;
                end
            end

            ST_DRAIN: begin
                // Advance only on acceptance; otherwise the beat holds
                if (drain_valid_q && drain_ready_i) begin
                    if (drain_addr_q == LAST_ADDR) begin
                        drain_valid_d = 1'b0;
                        state_d       = ST_IDLE;
                    end else begin
                        drain_addr_d = drain_addr_next;
                        drain_data_d = mem[drain_addr_next];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            mem_valid_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            drain_valid_q <= 1'b0;
            drain_addr_q  <= '0;
            drain_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            mem_valid_q   <= mem_valid_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            drain_valid_q <= drain_valid_d;
            drain_addr_q  <= drain_addr_d;
            drain_data_q  <= drain_data_d;
        end
    end

    // Storage write; suppressed during reset so an aborted clear stops at once
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign memory_data_o  = mem_data_q;
    assign memory_addr_o  = mem_addr_q;
    assign memory_valid_o = mem_valid_q;
    assign drain_data_o   = drain_data_q;
    assign drain_addr_o   = drain_addr_q;
    assign drain_valid_o  = drain_valid_q;
    assign busy_o         = (state_q == ST_CLEAR) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_cim_acc_buffer.sv
// Directed bench for cim_acc_buffer: clear, fetch latency, write forwarding,
// an RMW accumulation loop, a throttled drain, reset during clear, and
// clear/drain priority.
`timescale 1ns/1ps
module tb_cim_acc_buffer;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 512;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_req_valid_i;
    logic [ADDR_W-1:0] rd_req_addr_i;
    logic [DATA_W-1:0] memory_data_o;
    logic [ADDR_W-1:0] memory_addr_o;
    logic              memory_valid_o;
    logic              wr_valid_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              clear_i;
    logic              drain_i;
    logic [DATA_W-1:0] drain_data_o;
    logic [ADDR_W-1:0] drain_addr_o;
    logic              drain_valid_o;
    logic              drain_ready_i;
    logic              busy_o;

    always #5 clk = ~clk;

    cim_acc_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .rd_req_valid_i (rd_req_valid_i),
        .rd_req_addr_i  (rd_req_addr_i),
        .memory_data_o  (memory_data_o),
        .memory_addr_o  (memory_addr_o),
        .memory_valid_o (memory_valid_o),
        .wr_valid_i     (wr_valid_i),
        .wr_addr_i      (wr_addr_i),
        .wr_data_i      (wr_data_i),
        .clear_i        (clear_i),
        .drain_i        (drain_i),
        .drain_data_o   (drain_data_o),
        .drain_addr_o   (drain_addr_o),
        .drain_valid_o  (drain_valid_o),
        .drain_ready_i  (drain_ready_i),
        .busy_o         (busy_o)
    );

    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] shadow [DEPTH];

    task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] tile(input logic [11:0] v);
        logic [DATA_W-1:0] t;
        t = '0;
        for (int i = 0; i < 36; i++) t[i*12 +: 12] = v;
        return t;
    endfunction

    // Adder model: element-wise 12-bit wrap-around add of two packed tiles
    function automatic logic [DATA_W-1:0] add_tile(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] t;
        t = '0;
        for (int i = 0; i < 36; i++) t[i*12 +: 12] = a[i*12 +: 12] + b[i*12 +: 12];
        return t;
    endfunction

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_valid_i = 1'b1;
        wr_addr_i  = a;
        wr_data_i  = d;
        tick;
        wr_valid_i = 1'b0;
        shadow[a]  = d;
    endtask

    task automatic do_read(input string tag, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] exp);
        rd_req_valid_i = 1'b1;
        rd_req_addr_i  = a;
        tick;
        rd_req_valid_i = 1'b0;
        check_val({tag, ".valid"}, DATA_W'(memory_valid_o), DATA_W'(1));
        check_val({tag, ".addr"},  DATA_W'(memory_addr_o),  DATA_W'(a));
        check_val({tag, ".data"},  memory_data_o, exp);
    endtask

    task automatic do_clear(input string tag);
        int n;
        clear_i = 1'b1;
        tick;
        clear_i = 1'b0;
        n = 0;
        while (busy_o && n < 1000) begin
            n++;
            tick;
        end
        check_val({tag, ".busy_cycles"}, DATA_W'(n), DATA_W'(DEPTH));
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] x_val, y_val, held_d, p254;
        logic [ADDR_W-1:0] held_a;
        logic              pat [4];
        logic              was_ready;
        int                n, beats, cyc, dv_seen;

        reset          = 1'b1;
        rd_req_valid_i = 1'b0;
        rd_req_addr_i  = '0;
        wr_valid_i     = 1'b0;
        wr_addr_i      = '0;
        wr_data_i      = '0;
        clear_i        = 1'b0;
        drain_i        = 1'b0;
        drain_ready_i  = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

        // Reset state
        repeat (3) tick;
        check_val("rst.busy",     DATA_W'(busy_o),         '0);
        check_val("rst.mvalid",   DATA_W'(memory_valid_o), '0);
        check_val("rst.mdata",    memory_data_o,           '0);
        check_val("rst.dvalid",   DATA_W'(drain_valid_o),  '0);
        check_val("rst.ddata",    drain_data_o,            '0);
        reset = 1'b0;
        tick;

        // Clear: busy for exactly DEPTH cycles; traffic during clear is dropped
        clear_i = 1'b1;
        tick;
        clear_i = 1'b0;
        n = 0;
        while (busy_o && n < 1000) begin
            if (n == 10) begin
                rd_req_valid_i = 1'b1;
                rd_req_addr_i  = 8'd3;
                wr_valid_i     = 1'b1;
                wr_addr_i      = 8'd3;
                wr_data_i      = tile(12'h005);
            end
            if (n == 11) begin
                rd_req_valid_i = 1'b0;
                wr_valid_i     = 1'b0;
                check_val("clr.rd_ignored", DATA_W'(memory_valid_o), '0);
            end
            n++;
            tick;
        end
        check_val("clr.busy_cycles", DATA_W'(n), DATA_W'(DEPTH));
        do_read("clr.rd0",   8'd0,   '0);
        do_read("clr.rd128", 8'd128, '0);
        do_read("clr.rd255", 8'd255, '0);
        tick;
        check_val("rd.valid_drops", DATA_W'(memory_valid_o), '0);
        do_read("clr.rd3_wr_dropped", 8'd3, '0);

        // Write then fetch
        do_write(8'd5, tile(12'h001));
        do_read("wr5", 8'd5, tile(12'h001));

        // Same-cycle write/read hazard
        y_val = tile(12'h0AB);
        x_val = {80'h0, {27{16'h5A3C}}};
        do_write(8'd9, y_val);
        wr_valid_i = 1'b1; wr_addr_i = 8'd9; wr_data_i = x_val;
        rd_req_valid_i = 1'b1; rd_req_addr_i = 8'd9;
        tick;
        wr_valid_i = 1'b0; rd_req_valid_i = 1'b0;
        shadow[9] = x_val;
        check_val("fwd9.data", memory_data_o, x_val);
        check_val("fwd9.addr", DATA_W'(memory_addr_o), DATA_W'(9));
        do_write(8'd9, y_val);
        wr_valid_i = 1'b1; wr_addr_i = 8'd10; wr_data_i = x_val;
        rd_req_valid_i = 1'b1; rd_req_addr_i = 8'd9;
        tick;
        wr_valid_i = 1'b0; rd_req_valid_i = 1'b0;
        shadow[10] = x_val;
        check_val("nofwd9.data", memory_data_o, y_val);
        do_read("rd10", 8'd10, x_val);

        // Read-modify-write accumulation through the adder model
        do_clear("rmw.clr");
        for (int k = 0; k < 4; k++) begin
            do_read($sformatf("rmw.acc%0d", k), 8'd7, tile(12'(3 * k)));
            do_write(8'd7, add_tile(memory_data_o, tile(12'h003)));
        end
        do_read("rmw.sum12", 8'd7, tile(12'h00C));
        do_write(8'd7, add_tile(memory_data_o, tile(12'hFF4)));
        do_read("rmw.sum0", 8'd7, '0);

        // Drain with ready toggling 1,0,0,1
        p254 = {80'h0, {27{16'hBEEF}}};
        do_write(8'd0,   tile(12'h111));
        do_write(8'd1,   tile(12'h222));
        do_write(8'd100, tile(12'h0A5));
        do_write(8'd254, p254);
        do_write(8'd255, tile(12'hFFF));
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        drain_i = 1'b1;
        tick;
        drain_i = 1'b0;
        check_val("drn.busy", DATA_W'(busy_o), DATA_W'(1));
        beats = 0;
        cyc   = 0;
        while (beats < DEPTH && cyc < 2000) begin
            drain_ready_i = pat[cyc % 4];
            was_ready     = pat[cyc % 4];
            if (!drain_valid_o) begin
                check_val("drn.valid", DATA_W'(drain_valid_o), DATA_W'(1));
            end
            if (was_ready) begin
                check_val($sformatf("drn.beat%0d.addr", beats), DATA_W'(drain_addr_o), DATA_W'(beats));
                check_val($sformatf("drn.beat%0d.data", beats), drain_data_o, shadow[beats]);
                beats++;
            end else begin
                held_a = drain_addr_o;
                held_d = drain_data_o;
            end
            tick;
            cyc++;
            if (!was_ready) begin
                if (drain_addr_o !== held_a || drain_data_o !== held_d || !drain_valid_o) begin
                    check_val("drn.hold.addr",  DATA_W'(drain_addr_o), DATA_W'(held_a));
                    check_val("drn.hold.data",  drain_data_o, held_d);
                    check_val("drn.hold.valid", DATA_W'(drain_valid_o), DATA_W'(1));
                end
            end
        end
        drain_ready_i = 1'b0;
        check_val("drn.beats",     DATA_W'(beats), DATA_W'(DEPTH));
        check_val("drn.busy_drop", DATA_W'(busy_o), '0);
        check_val("drn.valid_end", DATA_W'(drain_valid_o), '0);
        do_read("drn.unmodified100", 8'd100, tile(12'h0A5));

        // Reset in the middle of a clear
        do_write(8'd50,  tile(12'h032));
        do_write(8'd99,  tile(12'h063));
        do_write(8'd100, tile(12'h064));
        do_write(8'd200, tile(12'h0C8));
        clear_i = 1'b1;
        tick;
        clear_i = 1'b0;
        repeat (100) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_val("abort.busy",   DATA_W'(busy_o), '0);
        check_val("abort.mdata",  memory_data_o, '0);
        tick;
        check_val("abort.idle",   DATA_W'(busy_o), '0);
        do_read("abort.rd0",   8'd0,   '0);
        do_read("abort.rd50",  8'd50,  '0);
        do_read("abort.rd99",  8'd99,  '0);
        do_read("abort.rd100", 8'd100, tile(12'h064));
        do_read("abort.rd200", 8'd200, tile(12'h0C8));
        do_read("abort.rd254", 8'd254, p254);

        // clear_i and drain_i together: clear wins, no drain beats
        drain_ready_i = 1'b1;
        clear_i = 1'b1;
        drain_i = 1'b1;
        tick;
        clear_i = 1'b0;
        drain_i = 1'b0;
        n = 0;
        dv_seen = 0;
        while (busy_o && n < 1000) begin
            if (drain_valid_o) dv_seen++;
            n++;
            tick;
        end
        if (drain_valid_o) dv_seen++;
        drain_ready_i = 1'b0;
        check_val("prio.busy_cycles", DATA_W'(n), DATA_W'(DEPTH));
        check_val("prio.no_drain",    DATA_W'(dv_seen), '0);
        do_read("prio.rd200", 8'd200, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
